// File: rtl/reg_dest_scoreboard_pkg.sv
// Shared datapath definitions for the destination-register scoreboard:
// register widths, the zero register, and the {valid, dest} pipeline slot record.
package reg_dest_scoreboard_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] dest;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{valid: 1'b0, dest: REG_ZERO};

  // True when an occupied slot will write the given register.
  function automatic logic slot_hit(input slot_t s, input logic [ADDR_W-1:0] r);
    return s.valid && (s.dest == r);
  endfunction

endpackage

// File: rtl/reg_dest_scoreboard_reg_file.sv
// 32-entry two-read/one-write register file with a hardwired zero register
// and write-first bypass so WB results are visible to ID in the same cycle.
module reg_file_2r1w
  import reg_dest_scoreboard_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != REG_ZERO)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Zero register wins over the bypass, the bypass wins over stored contents.
  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    if (raddr1_i == REG_ZERO) begin
      rdata1_o = '0;
    end else if (we_i && (waddr_i == raddr1_i)) begin
      rdata1_o = wdata_i;
    end
  end

  always_comb begin
    rdata2_o = regs_q[raddr2_i];
    if (raddr2_i == REG_ZERO) begin
      rdata2_o = '0;
    end else if (we_i && (waddr_i == raddr2_i)) begin
      rdata2_o = wdata_i;
    end
  end

endmodule

// File: rtl/reg_dest_scoreboard.sv
// Tracks in-flight destination registers through EX/MEM/WB, raises the
// read-after-write stall for ID, and owns the register file that WB writes.
module reg_dest_scoreboard
  import reg_dest_scoreboard_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              IssueValid,
  input  logic              IssueRegWrite,
  input  logic [ADDR_W-1:0] IssueDest,
  input  logic              Flush,
  input  logic [ADDR_W-1:0] Rs,
  input  logic [ADDR_W-1:0] Rt,
  input  logic              UseRs,
  input  logic              UseRt,
  input  logic [DATA_W-1:0] WbData,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              Stall,
  output logic              WbEn,
  output logic [ADDR_W-1:0] WbDest
);

  slot_t ex_q, ex_d;
  slot_t mem_q, mem_d;
  slot_t wb_q, wb_d;

  logic issue_ok;
  logic rs_hazard;
  logic rt_hazard;

  // Only EX and MEM can stall; a WB match is served by the register file bypass.
  always_comb begin
    rs_hazard = UseRs && (Rs != REG_ZERO) && (slot_hit(ex_q, Rs) || slot_hit(mem_q, Rs));
    rt_hazard = UseRt && (Rt != REG_ZERO) && (slot_hit(ex_q, Rt) || slot_hit(mem_q, Rt));
    Stall     = rs_hazard || rt_hazard;
  end

  // Invalid slots are stored as SLOT_EMPTY so WbDest reads 0 when nothing writes.
  always_comb begin
    issue_ok = IssueValid && IssueRegWrite && !Stall && !Flush && (IssueDest != REG_ZERO);
    ex_d     = SLOT_EMPTY;
    if (issue_ok) begin
      ex_d = '{valid: 1'b1, dest: IssueDest};
    end
    mem_d = Flush ? SLOT_EMPTY : ex_q;
    wb_d  = Flush ? SLOT_EMPTY : mem_q;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ex_q  <= SLOT_EMPTY;
      mem_q <= SLOT_EMPTY;
      wb_q  <= SLOT_EMPTY;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign WbEn   = wb_q.valid;
  assign WbDest = wb_q.dest;

  reg_file_2r1w u_reg_file (
    .clk_i    (Clk),
    .rst_ni   (Reset_n),
    .we_i     (WbEn),
    .waddr_i  (WbDest),
    .wdata_i  (WbData),
    .raddr1_i (Rs),
    .raddr2_i (Rt),
    .rdata1_o (ReadData1),
    .rdata2_o (ReadData2)
  );

endmodule

// File: tb/tb_reg_dest_scoreboard.sv
// Bench for reg_dest_scoreboard: an in-flight write list with ages plus a
// register array predicts each cycle's outputs; a monitor compares them.
module tb_reg_dest_scoreboard;

  localparam int EXP_W = 1 + 1 + 5 + 32 + 32;

  logic        Clk;
  logic        Reset_n;
  logic        IssueValid;
  logic        IssueRegWrite;
  logic [4:0]  IssueDest;
  logic        Flush;
  logic [4:0]  Rs;
  logic [4:0]  Rt;
  logic        UseRs;
  logic        UseRt;
  logic [31:0] WbData;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic        Stall;
  logic        WbEn;
  logic [4:0]  WbDest;

  reg_dest_scoreboard dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .IssueValid    (IssueValid),
    .IssueRegWrite (IssueRegWrite),
    .IssueDest     (IssueDest),
    .Flush         (Flush),
    .Rs            (Rs),
    .Rt            (Rt),
    .UseRs         (UseRs),
    .UseRt         (UseRt),
    .WbData        (WbData),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2),
    .Stall         (Stall),
    .WbEn          (WbEn),
    .WbDest        (WbDest)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- reference model ----------------
  // An instruction that writes a register is in flight for three cycles after
  // issue: ages 0 and 1 (EX, MEM) can stall readers, age 2 is the write cycle.
  typedef struct {
    logic [4:0] dest;
    int         age;
  } inflight_t;

  inflight_t   pend[$];
  logic [31:0] m_regs [32];

  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] model_read(input logic [4:0] r, input logic wen,
                                             input logic [4:0] wdest, input logic [31:0] wdata);
    if (r == 5'd0) return 32'd0;
    if (wen && wdest == r) return wdata;
    return m_regs[r];
  endfunction

  task automatic model_clear();
    pend.delete();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge: drive inputs, predict, advance over one edge.
  task automatic step(input logic iv, input logic irw, input logic [4:0] idest,
                      input logic fl, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic [31:0] wbd);
    logic        e_stall;
    logic        e_wben;
    logic [4:0]  e_wbdest;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    inflight_t   nq[$];
    IssueValid    = iv;
    IssueRegWrite = irw;
    IssueDest     = idest;
    Flush         = fl;
    Rs            = rs;
    Rt            = rt;
    UseRs         = urs;
    UseRt         = urt;
    WbData        = wbd;
    e_stall  = 1'b0;
    e_wben   = 1'b0;
    e_wbdest = 5'd0;
    foreach (pend[i]) begin
      if (pend[i].age == 2) begin
        e_wben   = 1'b1;
        e_wbdest = pend[i].dest;
      end else if ((urs && rs != 5'd0 && pend[i].dest == rs) ||
                   (urt && rt != 5'd0 && pend[i].dest == rt)) begin
        e_stall = 1'b1;
      end
    end
    e_rd1 = model_read(rs, e_wben, e_wbdest, wbd);
    e_rd2 = model_read(rt, e_wben, e_wbdest, wbd);
    exp_q.push_back({e_stall, e_wben, e_wbdest, e_rd1, e_rd2});
    @(posedge Clk);
    if (Reset_n) begin
      if (e_wben) m_regs[e_wbdest] = wbd;
      foreach (pend[i]) begin
        if (pend[i].age == 2) continue;
        if (fl) continue;
        nq.push_back('{dest: pend[i].dest, age: pend[i].age + 1});
      end
      if (iv && irw && !e_stall && !fl && idest != 5'd0) nq.push_back('{dest: idest, age: 0});
      pend = nq;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, $urandom);
  endtask

  task automatic read_regs(input logic [4:0] rs, input logic [4:0] rt);
    step(0, 0, 0, 0, rs, rt, 1, 1, $urandom);
  endtask

  task automatic do_reset(input int cycles);
    Reset_n = 1'b0;
    model_clear();
    for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 5'd9, 5'd3, 1, 1, $urandom);
    Reset_n = 1'b1;
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %08h expected %08h", name, $time, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    logic [EXP_W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("stall",      {31'd0, Stall},     {31'd0, e[70]});
      check("wb_en",      {31'd0, WbEn},      {31'd0, e[69]});
      check("wb_dest",    {27'd0, WbDest},    {27'd0, e[68:64]});
      check("read_data1", ReadData1,          e[63:32]);
      check("read_data2", ReadData2,          e[31:0]);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    Reset_n = 1'b0;
    IssueValid = 0; IssueRegWrite = 0; IssueDest = 0; Flush = 0;
    Rs = 0; Rt = 0; UseRs = 0; UseRt = 0; WbData = 0;
    model_clear();
    @(posedge Clk);
    #1;
    do_reset(2);

    // Reset state readback
    read_regs(5'd5, 5'd0);

    // RAW hazard on dest 8: two stall cycles, then bypass
    step(1, 1, 5'd8, 0, 0, 0, 0, 0, $urandom);
    for (int i = 0; i < 3; i++) step(1, 0, 5'd0, 0, 5'd8, 5'd0, 1, 0, 32'h1234_0000 + i);
    idle(3);

    // Writes to register 0 never track or write
    step(1, 1, 5'd0, 0, 0, 0, 0, 0, $urandom);
    for (int i = 0; i < 4; i++) read_regs(5'd0, 5'd0);

    // One and two independent instructions between writer and reader
    step(1, 1, 5'd6, 0, 0, 0, 0, 0, $urandom);
    step(1, 1, 5'd7, 0, 0, 0, 0, 0, $urandom);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 5'd6, 5'd0, 1, 0, $urandom);
    idle(3);

    // Flush squashes dest 12 even while it stalls the reader
    step(1, 1, 5'd12, 0, 0, 0, 0, 0, $urandom);
    step(1, 1, 5'd13, 1, 5'd0, 5'd12, 0, 1, $urandom);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 5'd0, 5'd12, 0, 1, $urandom);

    // Write and read back reg 3
    step(1, 1, 5'd3, 0, 0, 0, 0, 0, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF);
    read_regs(5'd3, 5'd3);

    // Reset while dest 9 sits in MEM loses the write
    step(1, 1, 5'd9, 0, 0, 0, 0, 0, $urandom);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'hCAFE_0009);
    do_reset(2);
    idle(3);
    read_regs(5'd9, 5'd3);

    // Randomized traffic over a narrow register range to force hazards
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
           $urandom_range(0, 9) == 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom);
      if ($urandom_range(0, 499) == 0) do_reset(1);
    end
    idle(4);

    @(negedge Clk);
    #1;
    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog at %0t: got timeout expected completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_dest_scoreboard.md
# reg_dest_scoreboard

Tracks the 5-bit destination register numbers produced by the datapath's destination-select mux as instructions move through EX, MEM and WB. Holds the 32-entry general-purpose register file that WB writes into. Raises a read-after-write stall when a decode-stage source register matches an in-flight destination. Sits between decode (ID) and write-back, replacing the bare register file in the datapath.

## Interface
- DATA_W, 32, register data width
- ADDR_W, 5, register number width (32 registers)
- Clk  in  1  rising-edge clock
- Reset_n  in  1  asynchronous, active-low reset
- IssueValid  in  1  ID instruction advances into EX this cycle (ignored while Stall=1)
- IssueRegWrite  in  1  issuing instruction writes a register
- IssueDest  in  ADDR_W  destination number from destination-select mux
- Flush  in  1  squash EX and MEM slots (branch/jump taken)
- Rs, Rt  in  ADDR_W  ID source register numbers
- UseRs, UseRt  in  1  source actually read by ID instruction
- WbData  in  DATA_W  result of instruction currently in WB slot
- ReadData1, ReadData2  out  DATA_W  register contents for Rs, Rt
- Stall  out  1  hold ID/IF, insert bubble
- WbEn  out  1  WB slot valid and writing
- WbDest  out  ADDR_W  register being written this cycle

## Operation
- Three slots, EX→MEM→WB, each {valid, dest}. Slots shift every cycle; pipeline never stalls past ID.
- EX slot loads {IssueValid & IssueRegWrite & ~Stall & ~Flush & (IssueDest≠0), IssueDest}; otherwise bubble (valid=0).
- Flush: EX and MEM slots become invalid on that edge; the shifted-in WB slot takes old MEM only if Flush=0. The issuing instruction that cycle is also discarded.
- Register file: 32×DATA_W, register 0 reads 0 always, writes to 0 ignored. Write on rising edge when WbEn=1: reg[WbDest] ← WbData.
- Reads combinational. Write-first bypass: if WbEn and WbDest==Rs (≠0), ReadData1=WbData; same for Rt/ReadData2.
- Stall = (UseRs & Rs≠0 & Rs matches valid EX or MEM dest) | (same for Rt). WB slot never causes a stall (bypass covers it).
- Matches against flushed slots do not count; Stall is purely combinational from current slot state.

## Timing
- Reset (async assert, sync-safe deassert): all slot valids 0, register file cleared to 0; outputs: Stall=0, WbEn=0, WbDest=0, ReadData1/2=0.
- Issue at edge N: dest in EX during N..N+1, MEM after N+1, WB after N+2; register written at edge N+3, visible through bypass in cycle N+2..N+3.
- Dependent instruction behind a writer sees Stall for exactly 2 cycles, 1 cycle if one independent instruction intervenes, 0 if two.
- Simultaneous Flush and Stall: Flush wins; slots cleared, Stall drops next cycle unless WB-only match (never stalls).
- Reset mid-operation: all pending writes lost, no write on the reset edge.

## Structure
- Shared datapath package: ADDR_W, DATA_W, REG_ZERO=0, slot record {valid, dest}.
- One sub-module natural: reg_file_2r1w (storage + zero register + write-first bypass); scoreboard slots and hazard compare in the top.

## Test plan
- Reset then read Rs=5, Rt=0 → ReadData1=0, ReadData2=0, Stall=0, WbEn=0.
- Issue dest=8, next cycle ID UseRs, Rs=8 → Stall=1 for 2 cycles, then ReadData1=WbData (bypass), Stall=0.
- Issue dest=0 with IssueRegWrite=1, then read Rs=0 → Stall=0, WbEn=0, ReadData1=0.
- Issue dest=12, Flush next cycle, ID Rt=12 UseRt → Stall=0 after flush, WbEn never asserts for 12.
- Issue dest=3, WbData=0xDEADBEEF at WB → edge writes reg3; later read Rs=3 → 0xDEADBEEF.
- Issue dest=9, Reset_n low while in MEM → WbEn stays 0, reg9 reads 0 after reset.
